// File: rtl/stopwatch_bcd_datapath_if.sv
// Strobe/result bundle between the stopwatch control FSM and its BCD datapath.
// master = control side (drives strobes), slave = datapath side.
interface stopwatch_bcd_datapath_if #(
    parameter int DIGITS = 4
);
    logic                ci;
    logic                ld;
    logic                clr;
    logic [4*DIGITS-1:0] cnt;
    logic [4*DIGITS-1:0] disp;
    logic                ovf;

    modport master (
        output ci, ld, clr,
        input  cnt, disp, ovf
    );

    modport slave (
        input  ci, ld, clr,
        output cnt, disp, ovf
    );
endinterface

// File: rtl/stopwatch_bcd_datapath.sv
// Prescaled BCD running counter with lap display register.
// Optional macro BCD_SAT_EN: saturate at all-9s with sticky ovf instead of wrapping.
module stopwatch_bcd_datapath #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 4,
    parameter int PRE_W    = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    stopwatch_bcd_datapath_if.slave  bus
);
    localparam int W = 4 * DIGITS;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;
    logic [W-1:0]     cnt_q, cnt_d;
    logic [W-1:0]     disp_q, disp_d;
    logic             ovf_q, ovf_d;
    logic [W-1:0]     cnt_inc;
    logic             all9;
    logic             tick;

    assign tick = bus.ci && (pre_q == PRE_LAST);

    // Ripple BCD increment: carry walks up through every digit holding 9.
    always_comb begin : bcd_inc
        logic carry;
        carry   = 1'b1;
        all9    = 1'b1;
        cnt_inc = cnt_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q[4*i +: 4] != 4'd9) all9 = 1'b0;
            if (carry) begin
                if (cnt_q[4*i +: 4] == 4'd9) begin
                    cnt_inc[4*i +: 4] = 4'd0;
                end else begin
                    cnt_inc[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    always_comb begin
        pre_d  = pre_q;
        cnt_d  = cnt_q;
        disp_d = disp_q;
        ovf_d  = 1'b0;
        if (bus.clr) begin
            pre_d  = '0;
            cnt_d  = '0;
            disp_d = '0;
            ovf_d  = 1'b0;
        end else begin
            if (bus.ci) pre_d = tick ? '0 : pre_q + PRE_W'(1);
            if (bus.ld) disp_d = cnt_q;
`ifdef BCD_SAT_EN
            ovf_d = ovf_q;
            if (tick) begin
                if (all9) begin
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
`else
            // all-9s increments to all-0s naturally; flag it for one cycle
            ovf_d = tick && all9;
            if (tick) cnt_d = cnt_inc;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q  <= '0;
            cnt_q  <= '0;
            disp_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            cnt_q  <= cnt_d;
            disp_q <= disp_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.cnt  = cnt_q;
    assign bus.disp = disp_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_stopwatch_bcd_datapath.sv
// Bench for stopwatch_bcd_datapath: PRESCALE=4 and PRESCALE=1 instances
// against an integer-arithmetic reference model.
module tb_stopwatch_bcd_datapath;
    localparam int MAXV = 9999;
`ifdef BCD_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    stopwatch_bcd_datapath_if #(.DIGITS(4)) bus0 ();
    stopwatch_bcd_datapath_if #(.DIGITS(4)) bus1 ();

    stopwatch_bcd_datapath #(
        .DIGITS(4), .PRESCALE(4), .PRE_W(8)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    stopwatch_bcd_datapath #(
        .DIGITS(4), .PRESCALE(1), .PRE_W(8)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    int errors = 0;
    int checks = 0;

    int m_cnt[2];
    int m_pre[2];
    int m_disp[2];
    bit m_ovf[2];
    int presc[2] = '{4, 1};

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int div;
        r = '0;
        div = 1;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'((v / div) % 10);
            div = div * 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [15:0] v);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++)
            if ($isunknown(v[4*i +: 4]) || v[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    // Reference: value as an integer, prescaler as a modulo count of ci cycles.
    task automatic model_step(input int id, input bit r, input bit ci,
                              input bit ld, input bit clr);
        bit tk;
        if (r || clr) begin
            m_cnt[id] = 0; m_pre[id] = 0; m_disp[id] = 0; m_ovf[id] = 0;
            return;
        end
        tk = ci && (m_pre[id] == presc[id] - 1);
        if (ci) m_pre[id] = (m_pre[id] + 1) % presc[id];
        if (ld) m_disp[id] = m_cnt[id];
        if (!SAT) m_ovf[id] = 1'b0;
        if (tk) begin
            if (m_cnt[id] == MAXV) begin
                m_ovf[id] = 1'b1;
                if (!SAT) m_cnt[id] = 0;
            end else begin
                m_cnt[id] = m_cnt[id] + 1;
            end
        end
    endtask

    task automatic cyc2(input bit r,
                        input bit c0, input bit l0, input bit k0,
                        input bit c1, input bit l1, input bit k1);
        rst = r;
        bus0.ci = c0; bus0.ld = l0; bus0.clr = k0;
        bus1.ci = c1; bus1.ld = l1; bus1.clr = k1;
        @(posedge clk);
        model_step(0, r, c0, l0, k0);
        model_step(1, r, c1, l1, k1);
        #1;
    endtask

    task automatic cyc(input int id, input bit c, input bit l, input bit k);
        if (id == 0) cyc2(1'b0, c, l, k, 1'b0, 1'b0, 1'b0);
        else         cyc2(1'b0, 1'b0, 1'b0, 1'b0, c, l, k);
    endtask

    task automatic test_reset;
        cyc2(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        cyc2(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus0.cnt !== 16'h0000) begin
            errors++; $display("FAIL rst_cnt: got %h want 0000", bus0.cnt);
        end
        checks++;
        if (bus0.disp !== 16'h0000) begin
            errors++; $display("FAIL rst_disp: got %h want 0000", bus0.disp);
        end
        checks++;
        if (bus0.ovf !== 1'b0) begin
            errors++; $display("FAIL rst_ovf: got %b want 0", bus0.ovf);
        end
        checks++;
        if (bus1.cnt !== 16'h0000 || bus1.ovf !== 1'b0) begin
            errors++;
            $display("FAIL rst_b: got %h/%b want 0000/0", bus1.cnt, bus1.ovf);
        end
        for (int k = 1; k <= 8; k++) begin
            cyc(0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus0.cnt !== to_bcd(k / 4)) begin
                errors++;
                $display("FAIL presc_step%0d: got %h want %h",
                         k, bus0.cnt, to_bcd(k / 4));
            end
        end
        checks++;
        if (bus0.cnt !== 16'h0002) begin
            errors++; $display("FAIL presc_8: got %h want 0002", bus0.cnt);
        end
    endtask

    task automatic test_carry;
        int prev;
        cyc(0, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 5000 && m_cnt[0] < 1000; n++) begin
            prev = m_cnt[0];
            cyc(0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (!bcd_ok(bus0.cnt) || bus0.cnt !== to_bcd(m_cnt[0])) begin
                errors++;
                $display("FAIL carry_run: got %h want %h",
                         bus0.cnt, to_bcd(m_cnt[0]));
            end
            if (prev != m_cnt[0] && (m_cnt[0] == 10 || m_cnt[0] == 100
                                     || m_cnt[0] == 1000)) begin
                checks++;
                if (bus0.cnt !== to_bcd(m_cnt[0])) begin
                    errors++;
                    $display("FAIL carry_%0d: got %h", m_cnt[0], bus0.cnt);
                end
            end
        end
        checks++;
        if (bus0.cnt !== 16'h1000) begin
            errors++; $display("FAIL carry_1000: got %h want 1000", bus0.cnt);
        end
    endtask

    task automatic test_freeze;
        bit pat[9] = '{1, 1, 0, 0, 0, 0, 0, 1, 1};
        int ones;
        cyc(0, 1'b0, 1'b0, 1'b1);
        ones = 0;
        for (int k = 0; k < 9; k++) begin
            cyc(0, pat[k], 1'b0, 1'b0);
            if (pat[k]) ones++;
            checks++;
            if (bus0.cnt !== to_bcd(ones / 4)) begin
                errors++;
                $display("FAIL freeze_c%0d: got %h want %h",
                         k, bus0.cnt, to_bcd(ones / 4));
            end
        end
        checks++;
        if (bus0.cnt !== 16'h0001) begin
            errors++; $display("FAIL freeze_end: got %h want 0001", bus0.cnt);
        end
    endtask

    task automatic test_lap;
        cyc(0, 1'b0, 1'b0, 1'b1);
        repeat (148) cyc(0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (bus0.cnt !== 16'h0037) begin
            errors++; $display("FAIL lap_pre: got %h want 0037", bus0.cnt);
        end
        repeat (3) cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (bus0.disp !== 16'h0037 || bus0.cnt !== 16'h0038) begin
            errors++;
            $display("FAIL lap_ld: got %h/%h want 0037/0038",
                     bus0.disp, bus0.cnt);
        end
        for (int k = 0; k < 8; k++) begin
            cyc(0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus0.disp !== 16'h0037) begin
                errors++; $display("FAIL lap_hold: got %h want 0037", bus0.disp);
            end
        end
        checks++;
        if (bus0.cnt !== 16'h0040) begin
            errors++; $display("FAIL lap_adv: got %h want 0040", bus0.cnt);
        end
    endtask

    task automatic test_clr_priority;
        repeat (3) cyc(0, 1'b1, 1'b0, 1'b0);
        cyc(0, 1'b1, 1'b1, 1'b1);
        checks++;
        if (bus0.cnt !== 16'h0 || bus0.disp !== 16'h0 || bus0.ovf !== 1'b0) begin
            errors++;
            $display("FAIL clr_prio: got %h/%h/%b want 0000/0000/0",
                     bus0.cnt, bus0.disp, bus0.ovf);
        end
        for (int k = 1; k <= 4; k++) begin
            cyc(0, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus0.cnt !== to_bcd(k / 4)) begin
                errors++;
                $display("FAIL clr_fresh%0d: got %h want %h",
                         k, bus0.cnt, to_bcd(k / 4));
            end
        end
    endtask

    task automatic test_wrap;
        logic [15:0] ec[3];
        bit eo[3];
        if (SAT) begin
            ec = '{16'h9999, 16'h9999, 16'h9999};
            eo = '{1'b0, 1'b1, 1'b1};
        end else begin
            ec = '{16'h9999, 16'h0000, 16'h0001};
            eo = '{1'b0, 1'b1, 1'b0};
        end
        cyc(1, 1'b0, 1'b0, 1'b1);
        for (int n = 0; n < 9998; n++) begin
            cyc(1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus1.cnt !== to_bcd(m_cnt[1]) || bus1.ovf !== m_ovf[1]) begin
                errors++;
                $display("FAIL wrap_run: got %h/%b want %h/%b", bus1.cnt,
                         bus1.ovf, to_bcd(m_cnt[1]), m_ovf[1]);
            end
        end
        checks++;
        if (bus1.cnt !== 16'h9998) begin
            errors++; $display("FAIL wrap_9998: got %h want 9998", bus1.cnt);
        end
        for (int k = 0; k < 3; k++) begin
            cyc(1, 1'b1, 1'b0, 1'b0);
            checks++;
            if (bus1.cnt !== ec[k] || bus1.ovf !== eo[k]) begin
                errors++;
                $display("FAIL wrap_%0d: got %h/%b want %h/%b",
                         k, bus1.cnt, bus1.ovf, ec[k], eo[k]);
            end
        end
        cyc(1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (bus1.ovf !== SAT || bus1.disp !== ec[2]) begin
            errors++;
            $display("FAIL wrap_idle: got %b/%h want %b/%h",
                     bus1.ovf, bus1.disp, SAT, ec[2]);
        end
        cyc(1, 1'b0, 1'b0, 1'b1);
        checks++;
        if (bus1.cnt !== 16'h0000 || bus1.ovf !== 1'b0) begin
            errors++;
            $display("FAIL wrap_clr: got %h/%b want 0000/0", bus1.cnt, bus1.ovf);
        end
    endtask

    task automatic test_random;
        bit c0, l0, k0, c1, l1, k1;
        for (int n = 0; n < 3000; n++) begin
            c0 = ($urandom_range(0, 3) != 0);
            l0 = ($urandom_range(0, 15) == 0);
            k0 = ($urandom_range(0, 99) == 0);
            c1 = ($urandom_range(0, 3) != 0);
            l1 = ($urandom_range(0, 15) == 0);
            k1 = ($urandom_range(0, 499) == 0);
            cyc2(1'b0, c0, l0, k0, c1, l1, k1);
            checks++;
            if (bus0.cnt !== to_bcd(m_cnt[0]) || bus0.disp !== to_bcd(m_disp[0])
                || bus0.ovf !== m_ovf[0]) begin
                errors++;
                $display("FAIL rand_a%0d: got %h/%h/%b want %h/%h/%b", n,
                         bus0.cnt, bus0.disp, bus0.ovf, to_bcd(m_cnt[0]),
                         to_bcd(m_disp[0]), m_ovf[0]);
            end
            checks++;
            if (bus1.cnt !== to_bcd(m_cnt[1]) || bus1.disp !== to_bcd(m_disp[1])
                || bus1.ovf !== m_ovf[1]) begin
                errors++;
                $display("FAIL rand_b%0d: got %h/%h/%b want %h/%h/%b", n,
                         bus1.cnt, bus1.disp, bus1.ovf, to_bcd(m_cnt[1]),
                         to_bcd(m_disp[1]), m_ovf[1]);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus0.ci = 1'b0; bus0.ld = 1'b0; bus0.clr = 1'b0;
        bus1.ci = 1'b0; bus1.ld = 1'b0; bus1.clr = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_cnt[i] = 0; m_pre[i] = 0; m_disp[i] = 0; m_ovf[i] = 1'b0;
        end
        test_reset();
        test_carry();
        test_freeze();
        test_lap();
        test_clr_priority();
        test_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
